// File: rtl/mem_stage_pkg.sv
// Shared definitions for the memory pipeline stage: widths, FSM encoding,
// the MEM/WB control bundle and small address helpers.
package mem_stage_pkg;

  localparam int REG_W   = 5;
  localparam int WORD_W  = 32;
  localparam int TIMEOUT = 15;

  // The cycle counter holds completed ACCESS cycles, so the last permitted
  // cycle of an access is the one where the count equals TIMEOUT-1.
  localparam logic [3:0] TIMEOUT_LAST = 4'(TIMEOUT - 1);

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_ACCESS = 1'b1
  } memState_e;

  // Plain constants mirror the enum for the legacy-style state register.
  localparam logic [0:0] IDLE   = ST_IDLE;
  localparam logic [0:0] ACCESS = ST_ACCESS;

  // Control bits of the MEM/WB register; these are refreshed every cycle.
  typedef struct packed {
    logic valid;
    logic regW;
    logic excMisalign;
    logic busErr;
  } wbCtrl_t;

  // Word accesses need the two low address bits clear.
  function automatic logic isAligned(input logic [1:0] addrLow);
    return (addrLow == 2'b00);
  endfunction

endpackage

// File: rtl/mem_access_unit_memwb_reg.sv
// MEM/WB pipeline register. Control bits follow their inputs every cycle so
// bubbles and one-cycle exception pulses need no extra logic; the payload
// (destination and data) only changes when a result is actually loaded.
module memwb_reg
  import mem_stage_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              ld,
  input  wbCtrl_t           ctrlIn,
  input  logic [REG_W-1:0]  desIn,
  input  logic [WORD_W-1:0] dataIn,
  output wbCtrl_t           ctrlOut,
  output logic [REG_W-1:0]  desOut,
  output logic [WORD_W-1:0] dataOut
);

  // Register the writeback bundle; async clear wipes every field.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ctrlOut <= '{valid: 1'b0, regW: 1'b0, excMisalign: 1'b0, busErr: 1'b0};
      desOut  <= {REG_W{1'b0}};
      dataOut <= {WORD_W{1'b0}};
    end else begin
      ctrlOut <= ctrlIn;
      if (ld) begin
        desOut  <= desIn;
        dataOut <= dataIn;
      end else begin
        desOut  <= desOut;
        dataOut <= dataOut;
      end
    end
  end

endmodule

// File: rtl/mem_access_unit.sv
// MEM stage: sequences data-memory accesses with a two-state FSM, stalls the
// upstream pipeline while waiting for acknowledge, flags misaligned accesses
// and bus timeouts, and feeds results into the MEM/WB register.
module mem_access_unit
  import mem_stage_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [WORD_W-1:0] bpc_in,
  input  logic [REG_W-1:0]  gpr_des_in,
  input  logic [WORD_W-1:0] alu_out_in,
  input  logic [WORD_W-1:0] gpr_b_in,
  input  logic              zero_in,
  input  logic              pc_sel_in,
  input  logic              mem_r_in,
  input  logic              mem_w_in,
  input  logic              reg_w_in,
  input  logic              mem_to_r_in,
  output logic              dm_req,
  output logic              dm_we,
  output logic [WORD_W-1:0] dm_addr,
  output logic [WORD_W-1:0] dm_wdata,
  input  logic [WORD_W-1:0] dm_rdata,
  input  logic              dm_ack,
  output logic              stall,
  output logic              branch_take,
  output logic [WORD_W-1:0] branch_target,
  output logic              wb_valid,
  output logic              wb_reg_w,
  output logic [REG_W-1:0]  wb_des,
  output logic [WORD_W-1:0] wb_data,
  output logic              exc_misalign,
  output logic              bus_err
);

  logic [0:0]        state_r;
  logic [0:0]        nextState_s;
  logic [3:0]        cycleCnt_r;
  logic              memOp_s;
  logic              aligned_s;
  logic              dmReq_s;
  logic              dmWe_s;
  logic              stallRaw_s;
  logic              wbLoad_s;
  wbCtrl_t           wbCtrlNext_s;
  wbCtrl_t           wbCtrl_s;
  logic [REG_W-1:0]  wbDesNext_s;
  logic [WORD_W-1:0] wbDataNext_s;

  assign branch_take   = pc_sel_in & zero_in;
  assign branch_target = bpc_in;

  // Next-state, memory handshake, stall and writeback selection.
  always_comb begin
    memOp_s      = mem_r_in | mem_w_in;
    aligned_s    = isAligned(alu_out_in[1:0]);
    nextState_s  = state_r;
    dmReq_s      = 1'b0;
    dmWe_s       = 1'b0;
    dm_addr      = alu_out_in;
    dm_wdata     = gpr_b_in;
    stallRaw_s   = 1'b0;
    wbLoad_s     = 1'b0;
    wbCtrlNext_s = '{valid: 1'b0, regW: 1'b0, excMisalign: 1'b0, busErr: 1'b0};
    wbDesNext_s  = gpr_des_in;
    wbDataNext_s = alu_out_in;
    case (state_r)
      IDLE: begin
        if (memOp_s && aligned_s) begin
          // Hold the instruction and insert a bubble while the access starts.
          stallRaw_s  = 1'b1;
          nextState_s = ACCESS;
        end else if (memOp_s) begin
          wbLoad_s                 = 1'b1;
          wbCtrlNext_s.valid       = 1'b1;
          wbCtrlNext_s.excMisalign = 1'b1;
        end else begin
          wbLoad_s           = 1'b1;
          wbCtrlNext_s.valid = 1'b1;
          wbCtrlNext_s.regW  = reg_w_in;
        end
      end
      ACCESS: begin
        dmReq_s = 1'b1;
        dmWe_s  = mem_w_in;
        if (dm_ack) begin
          // Acknowledge wins even on the timeout cycle.
          wbLoad_s           = 1'b1;
          wbCtrlNext_s.valid = 1'b1;
          wbCtrlNext_s.regW  = reg_w_in;
          wbDataNext_s       = mem_to_r_in ? dm_rdata : alu_out_in;
          nextState_s        = IDLE;
        end else if (cycleCnt_r == TIMEOUT_LAST) begin
          wbLoad_s            = 1'b1;
          wbCtrlNext_s.valid  = 1'b1;
          wbCtrlNext_s.busErr = 1'b1;
          nextState_s         = IDLE;
        end else begin
          stallRaw_s = 1'b1;
        end
      end
      default: begin
        nextState_s = IDLE;
      end
    endcase
  end

  // Reset gates the handshake and stall immediately, not just at the next edge.
  assign dm_req = dmReq_s & rst;
  assign dm_we  = dmWe_s & rst;
  assign stall  = stallRaw_s & rst;

  // FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= nextState_s;
    end
  end

  // Count completed ACCESS cycles; IDLE keeps it cleared for the next entry.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cycleCnt_r <= 4'd0;
    end else if (state_r == ACCESS) begin
      cycleCnt_r <= cycleCnt_r + 4'd1;
    end else begin
      cycleCnt_r <= 4'd0;
    end
  end

  memwb_reg uMemwbReg (
    .clk     (clk),
    .rst     (rst),
    .ld      (wbLoad_s),
    .ctrlIn  (wbCtrlNext_s),
    .desIn   (wbDesNext_s),
    .dataIn  (wbDataNext_s),
    .ctrlOut (wbCtrl_s),
    .desOut  (wb_des),
    .dataOut (wb_data)
  );

  assign wb_valid     = wbCtrl_s.valid;
  assign wb_reg_w     = wbCtrl_s.regW;
  assign exc_misalign = wbCtrl_s.excMisalign;
  assign bus_err      = wbCtrl_s.busErr;

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: a per-instruction timeline model builds the
// expected cycle-by-cycle outputs; one negedge process compares against it.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] bpc_in, alu_out_in, gpr_b_in, dm_rdata, dm_addr, dm_wdata, branch_target, wb_data;
  logic [4:0]  gpr_des_in, wb_des;
  logic        zero_in, pc_sel_in, mem_r_in, mem_w_in, reg_w_in, mem_to_r_in, dm_ack;
  logic        dm_req, dm_we, stall, branch_take, wb_valid, wb_reg_w, exc_misalign, bus_err;

  always #5 clk = ~clk;

  mem_access_unit dut (
    .clk(clk), .rst(rst), .bpc_in(bpc_in), .gpr_des_in(gpr_des_in), .alu_out_in(alu_out_in),
    .gpr_b_in(gpr_b_in), .zero_in(zero_in), .pc_sel_in(pc_sel_in), .mem_r_in(mem_r_in),
    .mem_w_in(mem_w_in), .reg_w_in(reg_w_in), .mem_to_r_in(mem_to_r_in), .dm_req(dm_req),
    .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata), .dm_rdata(dm_rdata), .dm_ack(dm_ack),
    .stall(stall), .branch_take(branch_take), .branch_target(branch_target),
    .wb_valid(wb_valid), .wb_reg_w(wb_reg_w), .wb_des(wb_des), .wb_data(wb_data),
    .exc_misalign(exc_misalign), .bus_err(bus_err)
  );

  // Result of one cycle as seen on the registered outputs one cycle later.
  typedef struct {
    logic        v, rw;
    logic [4:0]  d;
    logic [31:0] dat;
    logic        exc, berr;
  } res_t;

  typedef struct {
    logic        stall, req, we;
    logic [31:0] addr, wdata;
    logic        bt;
    logic [31:0] btgt;
    res_t        wb;
  } cyc_t;

  cyc_t expQ[$];
  res_t lastRes;
  bit   chkEn;
  int   checks, errors, stallCnt, reqCnt;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Compare process: every cycle with an expectation is checked at negedge.
  always @(negedge clk) begin : cmp
    cyc_t e;
    if (dm_req === 1'b1) reqCnt++;
    if (stall === 1'b1) stallCnt++;
    if (chkEn && expQ.size() > 0) begin
      e = expQ.pop_front();
      chk("stall", stall, e.stall);
      chk("dm_req", dm_req, e.req);
      if (e.req) begin
        chk("dm_we", dm_we, e.we);
        chk("dm_addr", dm_addr, e.addr);
        chk("dm_wdata", dm_wdata, e.wdata);
      end
      chk("branch_take", branch_take, e.bt);
      chk("branch_target", branch_target, e.btgt);
      chk("wb_valid", wb_valid, e.wb.v);
      chk("wb_reg_w", wb_reg_w, e.wb.rw);
      chk("exc_misalign", exc_misalign, e.wb.exc);
      chk("bus_err", bus_err, e.wb.berr);
      if (e.wb.v && e.wb.rw) begin
        chk("wb_des", wb_des, e.wb.d);
        chk("wb_data", wb_data, e.wb.dat);
      end
    end
  end

  // Record the expectation for the current cycle, then advance one clock.
  task automatic pushCyc(input logic st, input logic rq, input res_t r);
    cyc_t e;
    e.stall = st;
    e.req   = rq;
    e.we    = mem_w_in;
    e.addr  = alu_out_in;
    e.wdata = gpr_b_in;
    e.bt    = pc_sel_in & zero_in;
    e.btgt  = bpc_in;
    e.wb    = lastRes;
    expQ.push_back(e);
    lastRes = r;
    @(posedge clk);
    #1;
  endtask

  // Present one instruction and hold it for as long as the stage needs it.
  // ackDelay = number of unacknowledged ACCESS cycles before the ack.
  task automatic runInstr(input logic mr, input logic mw, input logic mtr, input logic rw,
                          input logic [4:0] des, input logic [31:0] addr, input logic [31:0] b,
                          input int ackDelay, input logic [31:0] rdata);
    res_t r;
    bit   done;
    int   k;
    mem_r_in = mr; mem_w_in = mw; mem_to_r_in = mtr; reg_w_in = rw;
    gpr_des_in = des; alu_out_in = addr; gpr_b_in = b;
    bpc_in = $urandom; pc_sel_in = 1'($urandom_range(0, 1)); zero_in = 1'($urandom_range(0, 1));
    dm_ack = 1'($urandom_range(0, 1));
    dm_rdata = $urandom;
    if (!(mr | mw)) begin
      r = '{1'b1, rw, des, addr, 1'b0, 1'b0};
      pushCyc(1'b0, 1'b0, r);
    end else if (addr[1:0] != 2'b00) begin
      r = '{1'b1, 1'b0, des, addr, 1'b1, 1'b0};
      pushCyc(1'b0, 1'b0, r);
    end else begin
      r = '{1'b0, 1'b0, des, addr, 1'b0, 1'b0};
      pushCyc(1'b1, 1'b0, r);
      done = 1'b0;
      k = 1;
      while (!done) begin
        if (k == ackDelay + 1) begin
          dm_ack = 1'b1; dm_rdata = rdata;
          r = '{1'b1, rw, des, (mtr ? rdata : addr), 1'b0, 1'b0};
          pushCyc(1'b0, 1'b1, r);
          done = 1'b1;
        end else if (k == 15) begin
          dm_ack = 1'b0; dm_rdata = $urandom;
          r = '{1'b1, 1'b0, des, addr, 1'b0, 1'b1};
          pushCyc(1'b0, 1'b1, r);
          done = 1'b1;
        end else begin
          dm_ack = 1'b0; dm_rdata = $urandom;
          r = '{1'b0, 1'b0, des, addr, 1'b0, 1'b0};
          pushCyc(1'b1, 1'b1, r);
        end
        k++;
      end
    end
    dm_ack = 1'b0;
  endtask

  task automatic chkWbZero(input string tag);
    chk({tag, "_stall"}, stall, 32'd0);
    chk({tag, "_dm_req"}, dm_req, 32'd0);
    chk({tag, "_wb_valid"}, wb_valid, 32'd0);
    chk({tag, "_wb_reg_w"}, wb_reg_w, 32'd0);
    chk({tag, "_wb_des"}, wb_des, 32'd0);
    chk({tag, "_wb_data"}, wb_data, 32'd0);
    chk({tag, "_exc"}, exc_misalign, 32'd0);
    chk({tag, "_bus_err"}, bus_err, 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1);
  end

  initial begin
    logic [31:0] a;
    int kind, sel, d;
    chkEn = 1'b0; checks = 0; errors = 0; stallCnt = 0; reqCnt = 0;
    lastRes = '{1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0};
    rst = 1'b0;
    bpc_in = 32'd0; gpr_des_in = 5'd0; alu_out_in = 32'd0; gpr_b_in = 32'd0;
    zero_in = 1'b0; pc_sel_in = 1'b0; mem_w_in = 1'b0; reg_w_in = 1'b0; mem_to_r_in = 1'b0;
    mem_r_in = 1'b1; dm_ack = 1'b0; dm_rdata = 32'd0;
    #3;
    chkWbZero("reset");
    @(posedge clk); #1;
    mem_r_in = 1'b0;
    rst = 1'b1;
    chkEn = 1'b1;

    // ALU op: one-cycle writeback, never stalls.
    stallCnt = 0;
    runInstr(1'b0, 1'b0, 1'b0, 1'b1, 5'd3, 32'h10, 32'h0, 0, 32'h0);
    chk("alu_wb_valid", wb_valid, 32'd1);
    chk("alu_wb_des", wb_des, 32'd3);
    chk("alu_wb_data", wb_data, 32'h10);
    chk("alu_stall_cycles", stallCnt, 32'd0);

    // Load acknowledged after three waiting ACCESS cycles.
    stallCnt = 0; reqCnt = 0;
    runInstr(1'b1, 1'b0, 1'b1, 1'b1, 5'd7, 32'h100, 32'h0, 3, 32'hDEADBEEF);
    chk("load_stall_cycles", stallCnt, 32'd4);
    chk("load_req_cycles", reqCnt, 32'd4);
    chk("load_wb_data", wb_data, 32'hDEADBEEF);
    chk("load_wb_reg_w", wb_reg_w, 32'd1);

    // Store with immediate ack.
    stallCnt = 0; reqCnt = 0;
    runInstr(1'b0, 1'b1, 1'b0, 1'b0, 5'd9, 32'h40, 32'h55, 0, 32'h0);
    chk("store_stall_cycles", stallCnt, 32'd1);
    chk("store_req_cycles", reqCnt, 32'd1);
    chk("store_wb_reg_w", wb_reg_w, 32'd0);

    // Misaligned load: no access, one-cycle exception.
    stallCnt = 0; reqCnt = 0;
    runInstr(1'b1, 1'b0, 1'b1, 1'b1, 5'd4, 32'h102, 32'h0, 0, 32'h0);
    chk("mis_req_cycles", reqCnt, 32'd0);
    chk("mis_stall_cycles", stallCnt, 32'd0);
    chk("mis_exc", exc_misalign, 32'd1);
    chk("mis_wb_reg_w", wb_reg_w, 32'd0);
    runInstr(1'b0, 1'b0, 1'b0, 1'b0, 5'd1, 32'h4, 32'h0, 0, 32'h0);
    chk("mis_exc_clear", exc_misalign, 32'd0);

    // No ack: timeout on the 15th ACCESS cycle.
    stallCnt = 0; reqCnt = 0;
    runInstr(1'b1, 1'b0, 1'b1, 1'b1, 5'd5, 32'h200, 32'h0, 20, 32'h0);
    chk("to_req_cycles", reqCnt, 32'd15);
    chk("to_stall_cycles", stallCnt, 32'd15);
    chk("to_bus_err", bus_err, 32'd1);
    chk("to_wb_reg_w", wb_reg_w, 32'd0);
    runInstr(1'b0, 1'b0, 1'b0, 1'b0, 5'd1, 32'h8, 32'h0, 0, 32'h0);
    chk("to_bus_err_clear", bus_err, 32'd0);

    // Ack on the 15th ACCESS cycle wins over the timeout.
    reqCnt = 0;
    runInstr(1'b1, 1'b0, 1'b1, 1'b1, 5'd6, 32'h204, 32'h0, 14, 32'hCAFEF00D);
    chk("late_req_cycles", reqCnt, 32'd15);
    chk("late_bus_err", bus_err, 32'd0);
    chk("late_wb_valid", wb_valid, 32'd1);
    chk("late_wb_data", wb_data, 32'hCAFEF00D);

    // Reset in ACCESS cycle 2: handshake drops at once, nothing written back.
    chkEn = 1'b0;
    mem_r_in = 1'b1; mem_w_in = 1'b0; mem_to_r_in = 1'b1; reg_w_in = 1'b1;
    alu_out_in = 32'h300; gpr_des_in = 5'd12; dm_ack = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("rst_pre_dm_req", dm_req, 32'd1);
    rst = 1'b0;
    #1;
    chkWbZero("midrst");
    @(posedge clk); #1;
    rst = 1'b1;
    lastRes = '{1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0};
    chkEn = 1'b1;
    runInstr(1'b1, 1'b0, 1'b1, 1'b1, 5'd12, 32'h300, 32'h0, 1, 32'h12345678);

    // Randomized instruction mix.
    for (int i = 0; i < 300; i++) begin
      kind = $urandom_range(0, 3);
      sel  = $urandom_range(0, 9);
      d    = (sel < 7) ? $urandom_range(0, 4) : ((sel == 7) ? 14 : ((sel == 8) ? 13 : 20));
      a    = $urandom;
      a[1:0] = 2'b00;
      case (kind)
        0: runInstr(1'b0, 1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    5'($urandom), $urandom, $urandom, 0, 32'h0);
        1: runInstr(1'b1, 1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    5'($urandom), a, $urandom, d, $urandom);
        2: runInstr(1'b0, 1'b1, 1'b0, 1'($urandom_range(0, 1)),
                    5'($urandom), a, $urandom, d, $urandom);
        default: begin
          a[1:0] = 2'($urandom_range(1, 3));
          runInstr(1'($urandom_range(0, 1)), 1'b1, 1'($urandom_range(0, 1)), 1'b1,
                   5'($urandom), a, $urandom, 0, 32'h0);
        end
      endcase
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
